// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
//   Shared definitions for the MIPS MEM stage:
//     - access-size codes (ex_size encoding)
//     - FSM state encoding for mem_access_unit
//     - big-endian lane positions (bit index of each lane's LSB)
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    // Big-endian: byte offset 0 is the most significant lane.
    localparam logic [4:0] BYTE0_LSB = 5'd24;
    localparam logic [4:0] BYTE1_LSB = 5'd16;
    localparam logic [4:0] BYTE2_LSB = 5'd8;
    localparam logic [4:0] BYTE3_LSB = 5'd0;
    localparam logic [4:0] HALF0_LSB = 5'd16;
    localparam logic [4:0] HALF1_LSB = 5'd0;

    function automatic logic [4:0] byte_lsb(input logic [1:0] off);
        case (off)
            2'd0:    return BYTE0_LSB;
            2'd1:    return BYTE1_LSB;
            2'd2:    return BYTE2_LSB;
            default: return BYTE3_LSB;
        endcase
    endfunction

    // Only addr[1] selects the half; addr[0] never moves the lane.
    function automatic logic [4:0] half_lsb(input logic off1);
        return off1 ? HALF1_LSB : HALF0_LSB;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit
//   Combinational lane logic for the MEM stage.
//   Ports:
//     size        in  2   access size code (SZ_*; 11 behaves as word)
//     is_unsigned in  1   zero-extend sub-word loads
//     offset      in  2   byte offset within the word (addr[1:0])
//     rdata       in  32  word read from data memory
//     wdata       in  32  store data (only low byte/half used for sub-word)
//     load_data   out 32  extracted and extended load value
//     merge_data  out 32  rdata with the addressed lane replaced by wdata
module mem_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  lsb;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask;

    always_comb begin
        lsb        = 5'd0;
        lane_b     = 8'd0;
        lane_h     = 16'd0;
        mask       = 32'd0;
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_BYTE: begin
                lsb        = byte_lsb(offset);
                lane_b     = 8'(rdata >> lsb);
                load_data  = {{24{~is_unsigned & lane_b[7]}}, lane_b};
                mask       = 32'h0000_00FF << lsb;
                merge_data = (rdata & ~mask) | ({24'd0, wdata[7:0]} << lsb);
            end
            SZ_HALF: begin
                lsb        = half_lsb(offset[1]);
                lane_h     = 16'(rdata >> lsb);
                load_data  = {{16{~is_unsigned & lane_h[15]}}, lane_h};
                mask       = 32'h0000_FFFF << lsb;
                merge_data = (rdata & ~mask) | ({16'd0, wdata[15:0]} << lsb);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MIPS MEM stage between the EX/MEM register and a 16x32 async-read data
//   memory. Word stores write directly; byte/half stores do a two-cycle
//   read-modify-write (IDLE reads and merges, RMW_WR writes) with a one-cycle
//   upstream stall. Results are registered into the MEM/WB fields.
//   Optional build macro: MEM_ALIGN_CHECK_EN -- misaligned half/word accesses
//   are suppressed and flagged on wb_misalign; otherwise wb_misalign is 0.
//   Ports:
//     clka, reset, clkEnable          clock, sync active-high reset, step enable
//     ex_*                            EX/MEM request (valid, read, write, size,
//                                     unsigned, addr, wdata, rd, reg_write)
//     stall_out                       hold upstream stages this cycle
//     mem_addr, mem_din, mem_we       data memory word index / write word / wea
//     mem_douta                       async read data from memory
//     wb_valid, wb_reg_write, wb_rd,
//     wb_data, wb_misalign            registered MEM/WB results
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 4
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  clkEnable,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_size,
    input  logic                  ex_unsigned,
    input  logic [DATA_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_write,
    output logic                  stall_out,
    output logic [MEM_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_douta,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_misalign
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [MEM_WIDTH-1:0]  rmw_addr_q, rmw_addr_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [MEM_WIDTH-1:0]  word_idx;
    logic [DATA_WIDTH-1:0] load_data, merge_data;
    logic                  misalign, mis_access, is_store, is_load, is_sub;

    // Upper address bits are intentionally dropped: accesses wrap at 16 words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ex_addr[DATA_WIDTH-1:MEM_WIDTH+2];

    assign word_idx = ex_addr[MEM_WIDTH+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (ex_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = ex_addr[0];
            default: misalign = |ex_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign mis_access = ex_valid & (ex_mem_read | ex_mem_write) & misalign;
    // A store wins over a simultaneous load; the load is then not performed.
    assign is_store   = ex_valid & ex_mem_write & ~misalign;
    assign is_load    = ex_valid & ex_mem_read & ~ex_mem_write & ~misalign;
    assign is_sub     = (ex_size == SZ_BYTE) | (ex_size == SZ_HALF);

    mem_lane_unit u_lane (
        .size        (ex_size),
        .is_unsigned (ex_unsigned),
        .offset      (ex_addr[1:0]),
        .rdata       (mem_douta),
        .wdata       (ex_wdata),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_comb begin
        state_d        = state_q;
        merge_d        = merge_q;
        rmw_addr_d     = rmw_addr_q;
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        mem_addr       = word_idx;
        mem_din        = ex_wdata;
        mem_we         = 1'b0;
        stall_out      = 1'b0;

        if (state_q == ST_RMW_WR) begin
            // wb fields were captured on entry; only the valid bubble is lifted.
            mem_addr   = rmw_addr_q;
            mem_din    = merge_q;
            mem_we     = clkEnable;
            wb_valid_d = 1'b1;
            state_d    = ST_IDLE;
        end else begin
            wb_valid_d     = ex_valid;
            wb_reg_write_d = ex_valid & ex_reg_write;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_addr;
            if (mis_access) begin
                wb_reg_write_d = 1'b0;
                wb_data_d      = '0;
            end else if (is_store && is_sub) begin
                stall_out  = 1'b1;
                merge_d    = merge_data;
                rmw_addr_d = word_idx;
                wb_valid_d = 1'b0;
                state_d    = ST_RMW_WR;
            end else if (is_store) begin
                mem_we = clkEnable;
            end else if (is_load) begin
                wb_data_d = load_data;
            end
        end

        // Reset drops any pending RMW write immediately.
        if (reset) begin
            mem_we    = 1'b0;
            stall_out = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
        end else if (clkEnable) begin
            state_q        <= state_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
        end
    end

    // Merge word and its address are only consumed in RMW_WR; no reset needed.
    always_ff @(posedge clka) begin
        if (clkEnable) begin
            merge_q    <= merge_d;
            rmw_addr_q <= rmw_addr_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic wb_misalign_q, wb_misalign_d;
    assign wb_misalign_d = (state_q == ST_IDLE) ? mis_access : wb_misalign_q;
    always_ff @(posedge clka) begin
        if (reset) begin
            wb_misalign_q <= 1'b0;
        end else if (clkEnable) begin
            wb_misalign_q <= wb_misalign_d;
        end
    end
    assign wb_misalign = wb_misalign_q;
`else
    assign wb_misalign = 1'b0;
`endif

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Scoreboard bench for mem_access_unit with a 16x32 async-read memory model.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clka = 1'b0;
    logic        reset, clkEnable;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_out, mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_din, mem_douta;
    logic        wb_valid, wb_reg_write, wb_misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] mem [16];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] data;
        logic        chk_data;
        logic        misalign;
    } exp_t;
    exp_t sbq[$];

    always #5 clka = ~clka;

    mem_access_unit #(.DATA_WIDTH(32), .MEM_WIDTH(4)) dut (
        .clka         (clka),
        .reset        (reset),
        .clkEnable    (clkEnable),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .stall_out    (stall_out),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_douta    (mem_douta),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_misalign  (wb_misalign)
    );

    assign mem_douta = mem[mem_addr];

    always @(posedge clka) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [4:0] rd, input logic rw,
                            input logic [31:0] data, input logic chk, input logic mis);
        exp_t e;
        e.tag = tag; e.rd = rd; e.reg_write = rw; e.data = data; e.chk_data = chk; e.misalign = mis;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw);
        ex_valid = v; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_size = sz;
        ex_unsigned = uns; ex_addr = addr; ex_wdata = wd; ex_rd = rd; ex_reg_write = rw;
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic load_op(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] exp);
        drive(1, 1, 0, sz, uns, addr, 32'h0, rd, 1);
        push_exp(tag, rd, 1, exp, 1, 0);
        step();
    endtask

    // Scoreboard monitor: pops one expectation per enabled, non-reset edge that
    // leaves wb_valid high.
    always @(posedge clka) begin : mon
        logic en_s, rst_s;
        exp_t e;
        en_s  = clkEnable;
        rst_s = reset;
        #2;
        if (!rst_s && en_s && wb_valid) begin
            if (sbq.size() == 0) begin
                check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                check_eq({e.tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
                check_eq({e.tag, "_regw"}, 32'(wb_reg_write), 32'(e.reg_write));
                check_eq({e.tag, "_mis"}, 32'(wb_misalign), 32'(e.misalign));
                if (e.chk_data) check_eq({e.tag, "_data"}, wb_data, e.data);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clkEnable = 1'b1; preload = 1'b1;
        drive(0, 0, 0, SZ_WORD, 0, 32'h0, 32'h0, 5'd0, 0);
        step();
        preload = 1'b0;

        // Leave stale wb values, then reset over them with a store pending.
        reset = 1'b0;
        drive(1, 0, 0, SZ_WORD, 0, 32'h0000_0055, 32'h0, 5'd3, 1);
        push_exp("alu_pre", 5'd3, 1, 32'h0000_0055, 1, 0);
        step();
        check_eq("stale_valid", 32'(wb_valid), 32'd1);
        reset = 1'b1;
        drive(1, 0, 1, SZ_WORD, 0, 32'h0000_0000, 32'hFFFF_FFFF, 5'd4, 1);
        mid();
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_stall", 32'(stall_out), 32'd0);
        step();
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_regw", 32'(wb_reg_write), 32'd0);
        check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_wb_mis", 32'(wb_misalign), 32'd0);
        check_eq("rst_mem0", mem[0], 32'h1000_0000);
        reset = 1'b0;

        // sw 0xDEADBEEF @0x08
        drive(1, 0, 1, SZ_WORD, 0, 32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 0);
        push_exp("sw08", 5'd0, 0, 32'h0, 0, 0);
        mid();
        check_eq("sw_we", 32'(mem_we), 32'd1);
        check_eq("sw_addr", 32'(mem_addr), 32'd2);
        check_eq("sw_din", mem_din, 32'hDEAD_BEEF);
        check_eq("sw_stall", 32'(stall_out), 32'd0);
        step();
        check_eq("sw_mem2", mem[2], 32'hDEAD_BEEF);

        // Loads of every size/extension from word 2.
        drive(1, 1, 0, SZ_WORD, 0, 32'h0000_0008, 32'h0, 5'd5, 1);
        mid();
        check_eq("lw_we", 32'(mem_we), 32'd0);
        check_eq("lw_stall", 32'(stall_out), 32'd0);
        push_exp("lw08", 5'd5, 1, 32'hDEAD_BEEF, 1, 0);
        step();
        load_op("lb08",  SZ_BYTE, 0, 32'h0000_0008, 5'd6,  32'hFFFF_FFDE);
        load_op("lbu0b", SZ_BYTE, 1, 32'h0000_000B, 5'd7,  32'h0000_00EF);
        load_op("lh0a",  SZ_HALF, 0, 32'h0000_000A, 5'd8,  32'hFFFF_BEEF);
        load_op("lhu08", SZ_HALF, 1, 32'h0000_0008, 5'd9,  32'h0000_DEAD);

        // ALU passthrough.
        drive(1, 0, 0, SZ_WORD, 0, 32'h1234_5678, 32'h0, 5'd12, 1);
        push_exp("alu", 5'd12, 1, 32'h1234_5678, 1, 0);
        step();

        // Invalid slot with write set: no access.
        drive(0, 0, 1, SZ_WORD, 0, 32'h0000_000C, 32'h0BAD_0BAD, 5'd0, 0);
        mid();
        check_eq("inv_we", 32'(mem_we), 32'd0);
        step();
        check_eq("inv_mem3", mem[3], 32'h1000_0003);

        // Read and write both set: store wins.
        drive(1, 1, 1, SZ_WORD, 0, 32'h0000_000C, 32'hCAFE_F00D, 5'd13, 0);
        push_exp("rdwr", 5'd13, 0, 32'h0, 0, 0);
        mid();
        check_eq("rdwr_we", 32'(mem_we), 32'd1);
        check_eq("rdwr_addr", 32'(mem_addr), 32'd3);
        step();
        check_eq("rdwr_mem3", mem[3], 32'hCAFE_F00D);

        // sb 0x12 @0x09: stall cycle then merged write.
        drive(1, 0, 1, SZ_BYTE, 0, 32'h0000_0009, 32'hFFFF_FF12, 5'd0, 0);
        push_exp("sb09", 5'd0, 0, 32'h0, 0, 0);
        mid();
        check_eq("sb_stall1", 32'(stall_out), 32'd1);
        check_eq("sb_we1", 32'(mem_we), 32'd0);
        step();
        check_eq("sb_bubble", 32'(wb_valid), 32'd0);
        mid();
        check_eq("sb_we2", 32'(mem_we), 32'd1);
        check_eq("sb_din", mem_din, 32'hDE12_BEEF);
        check_eq("sb_addr2", 32'(mem_addr), 32'd2);
        check_eq("sb_stall2", 32'(stall_out), 32'd0);
        step();
        check_eq("sb_wbvalid", 32'(wb_valid), 32'd1);
        check_eq("sb_mem2", mem[2], 32'hDE12_BEEF);

        // sb into the last lane.
        drive(1, 0, 1, SZ_BYTE, 0, 32'h0000_000F, 32'h0000_0077, 5'd0, 0);
        push_exp("sb0f", 5'd0, 0, 32'h0, 0, 0);
        step();
        step();
        check_eq("sb0f_mem3", mem[3], 32'hCAFE_F077);

        // Word access with upper address bits set and misaligned offset.
        drive(1, 1, 0, SZ_WORD, 0, 32'h0000_0042, 32'h0, 5'd9, 1);
`ifdef MEM_ALIGN_CHECK_EN
        push_exp("lw42", 5'd9, 0, 32'h0, 1, 1);
`else
        push_exp("lw42", 5'd9, 1, 32'h1000_0000, 1, 0);
`endif
        mid();
        check_eq("lw42_addr", 32'(mem_addr), 32'd0);
        step();

        // sh with reset asserted during RMW_WR: write dropped, back to IDLE.
        drive(1, 0, 1, SZ_HALF, 0, 32'h0000_0004, 32'h0000_AAAA, 5'd14, 1);
        mid();
        check_eq("shr_stall", 32'(stall_out), 32'd1);
        step();
        reset = 1'b1;
        mid();
        check_eq("shr_we", 32'(mem_we), 32'd0);
        check_eq("shr_stall2", 32'(stall_out), 32'd0);
        step();
        reset = 1'b0;
        check_eq("shr_mem1", mem[1], 32'h1000_0001);
        drive(1, 1, 0, SZ_WORD, 0, 32'h0000_0004, 32'h0, 5'd10, 1);
        push_exp("lw04", 5'd10, 1, 32'h1000_0001, 1, 0);
        mid();
        check_eq("post_rst_we", 32'(mem_we), 32'd0);
        check_eq("post_rst_addr", 32'(mem_addr), 32'd1);
        step();

        // sh with clkEnable low mid-RMW: write delayed, not lost.
        drive(1, 0, 1, SZ_HALF, 0, 32'h0000_0006, 32'h0000_1234, 5'd11, 1);
        push_exp("sh06", 5'd11, 1, 32'h0, 0, 0);
        step();
        clkEnable = 1'b0;
        mid();
        check_eq("ce_we1", 32'(mem_we), 32'd0);
        step();
        mid();
        check_eq("ce_we2", 32'(mem_we), 32'd0);
        step();
        check_eq("ce_mem1_hold", mem[1], 32'h1000_0001);
        clkEnable = 1'b1;
        mid();
        check_eq("ce_we3", 32'(mem_we), 32'd1);
        check_eq("ce_din", mem_din, 32'h1000_1234);
        check_eq("ce_addr", 32'(mem_addr), 32'd1);
        step();
        check_eq("ce_mem1", mem[1], 32'h1000_1234);

        drive(0, 0, 0, SZ_WORD, 0, 32'h0, 32'h0, 5'd0, 0);
        step();
        step();
        check_eq("sb_drain", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
